// File: rtl/sdram_init_gen.sv
// -----------------------------------------------------------------------------
// sdram_init_gen
//
// Parametrised SDRAM power-up initialisation sequencer. After reset it waits
// T_POW clocks and then issues the JEDEC sequence:
//   PRECHARGE-ALL, AREF_NUM x AUTO-REFRESH, LOAD MODE REGISTER,
//   and optionally LOAD EXTENDED MODE REGISTER.
// After that it raises init_end. While init_end is high, a one-cycle pulse on
// init_req restarts the sequence at PRECHARGE. A re-init skips the power-up
// wait.
//
// Ports
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   init_req   in   re-initialisation request; only honoured in DONE
//   init_cmd   out  {cs_n, ras_n, cas_n, we_n}
//   init_addr  out  address bus (ADDR_W)
//   init_ba    out  bank address (BA_W)
//   init_end   out  initialisation complete
//   init_busy  out  sequence running (inverse of init_end)
//
// All outputs are registered from the current state. A command therefore
// appears on the bus one clock after its state is entered.
// -----------------------------------------------------------------------------
module sdram_init_gen #(
  parameter int T_POW      = 33445,
  parameter int T_RP       = 4,
  parameter int T_RFC      = 12,
  parameter int T_MRD      = 6,
  parameter int AREF_NUM   = 6,
  parameter int CAS_LAT    = 3,
  parameter int BURST_LEN  = 0,
  parameter int BURST_TYPE = 0,
  parameter int WRITE_MODE = 0,
  parameter int EMR_EN     = 0,
  parameter int EMR_VAL    = 13'h0000,
  parameter int ADDR_W     = 13,
  parameter int BA_W       = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_req,
  output logic [3:0]        init_cmd,
  output logic [ADDR_W-1:0] init_addr,
  output logic [BA_W-1:0]   init_ba,
  output logic              init_end,
  output logic              init_busy
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (!(CAS_LAT == 2 || CAS_LAT == 3)) begin : g_bad_cas
    $error("sdram_init_gen: CAS_LAT must be 2 or 3");
  end
  if (!(BURST_LEN == 0 || BURST_LEN == 1 || BURST_LEN == 2 ||
        BURST_LEN == 4 || BURST_LEN == 8)) begin : g_bad_bl
    $error("sdram_init_gen: BURST_LEN must be 0, 1, 2, 4 or 8");
  end
  if (T_POW < 1 || T_RP < 1 || T_RFC < 1 || T_MRD < 1) begin : g_bad_t
    $error("sdram_init_gen: all wait times must be at least 1");
  end
  if (AREF_NUM < 1 || AREF_NUM > 255) begin : g_bad_aref
    $error("sdram_init_gen: AREF_NUM must be in 1..255");
  end
  if (ADDR_W < 10 || BA_W < 2) begin : g_bad_width
    $error("sdram_init_gen: ADDR_W must be >= 10 and BA_W must be >= 2");
  end
  if (BURST_TYPE > 1 || BURST_TYPE < 0 ||
      WRITE_MODE > 1 || WRITE_MODE < 0) begin : g_bad_mode
    $error("sdram_init_gen: BURST_TYPE and WRITE_MODE must be 0 or 1");
  end

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  localparam int T_MAX_A = (T_POW > T_RP) ? T_POW : T_RP;
  localparam int T_MAX_B = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CNT_W   = $clog2(T_MAX) + 1;

  // Terminal counts of the shared up-counter. POW and TRP last exactly T_x
  // cycles. The refresh and mode-load waits run one extra cycle (0..T_x), so
  // the command-to-command spacing becomes T_x+2. That extra cycle is margin
  // on tRFC/tMRD for the controller that takes over the bus.
  localparam logic [CNT_W-1:0] C_POW = CNT_W'(T_POW - 1);
  localparam logic [CNT_W-1:0] C_RP  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] C_RFC = CNT_W'(T_RFC);
  localparam logic [CNT_W-1:0] C_MRD = CNT_W'(T_MRD);

  localparam logic [7:0] AREF_LIM = 8'(AREF_NUM);

  localparam logic [2:0] BL_CODE = (BURST_LEN == 1) ? 3'b000 :
                                   (BURST_LEN == 2) ? 3'b001 :
                                   (BURST_LEN == 4) ? 3'b010 :
                                   (BURST_LEN == 8) ? 3'b011 : 3'b111;

  // Mode word layout: A9 write mode, A8:A7 = 00, A6:A4 CAS latency,
  // A3 burst type, A2:A0 burst length code. Bits above A9 stay zero.
  localparam logic [9:0] MODE_LO = {1'(WRITE_MODE), 2'b00, 3'(CAS_LAT),
                                    1'(BURST_TYPE), BL_CODE};
  localparam logic [ADDR_W-1:0] MODE_WORD = ADDR_W'(MODE_LO);
  localparam logic [ADDR_W-1:0] EMR_WORD  = ADDR_W'(EMR_VAL);
  localparam logic [BA_W-1:0]   EMR_BA    = BA_W'(2);  // BA1 = 1 selects EMR

  typedef enum logic [3:0] {
    S_POW, S_PRE, S_TRP, S_AREF, S_TRFC,
    S_LMR, S_TMRD, S_EMR, S_TEMR, S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [CNT_W-1:0]    r_wait;
  logic [7:0]          r_aref_cnt;
  logic [3:0]          r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic [BA_W-1:0]     r_ba;
  logic                r_end;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_POW;
      r_wait     <= '0;
      r_aref_cnt <= '0;
      r_cmd      <= CMD_NOP;
      r_addr     <= '1;
      r_ba       <= '1;
      r_end      <= 1'b0;
    end else begin
      // By default the wait counter counts up. Every state change below
      // reloads it to zero.
      r_wait <= r_wait + 1'b1;

      case (r_state)
        S_POW: begin
          if (r_wait == C_POW) begin
            r_state    <= S_PRE;
            r_wait     <= '0;
            r_aref_cnt <= '0;
          end
        end
        S_PRE: begin
          r_state <= S_TRP;
          r_wait  <= '0;
        end
        S_TRP: begin
          if (r_wait == C_RP) begin
            r_state <= S_AREF;
            r_wait  <= '0;
          end
        end
        S_AREF: begin
          r_state    <= S_TRFC;
          r_wait     <= '0;
          r_aref_cnt <= r_aref_cnt + 1'b1;
        end
        S_TRFC: begin
          if (r_wait == C_RFC) begin
            r_wait  <= '0;
            r_state <= (r_aref_cnt < AREF_LIM) ? S_AREF : S_LMR;
          end
        end
        S_LMR: begin
          r_state <= S_TMRD;
          r_wait  <= '0;
        end
        S_TMRD: begin
          if (r_wait == C_MRD) begin
            r_wait  <= '0;
            r_state <= (EMR_EN != 0) ? S_EMR : S_DONE;
          end
        end
        S_EMR: begin
          r_state <= S_TEMR;
          r_wait  <= '0;
        end
        S_TEMR: begin
          if (r_wait == C_MRD) begin
            r_state <= S_DONE;
            r_wait  <= '0;
          end
        end
        S_DONE: begin
          // Hold the counter still while idle. A request skips the power wait.
          r_wait <= '0;
          if (init_req) begin
            r_state    <= S_PRE;
            r_aref_cnt <= '0;
          end
        end
        default: begin
          r_state <= S_POW;
          r_wait  <= '0;
        end
      endcase

      // Outputs decoded from the current state and registered. Every state
      // without a command drives NOP with the address and bank lines high.
      r_cmd  <= CMD_NOP;
      r_addr <= '1;
      r_ba   <= '1;
      r_end  <= 1'b0;
      case (r_state)
        S_PRE:  r_cmd <= CMD_PRE;
        S_AREF: r_cmd <= CMD_AREF;
        S_LMR: begin
          r_cmd  <= CMD_LMR;
          r_addr <= MODE_WORD;
          r_ba   <= '0;
        end
        S_EMR: begin
          r_cmd  <= CMD_LMR;
          r_addr <= EMR_WORD;
          r_ba   <= EMR_BA;
        end
        // An accepted request drops init_end on the very next clock.
        S_DONE: r_end <= !init_req;
        default: ;
      endcase
    end
  end

  assign init_cmd  = r_cmd;
  assign init_addr = r_addr;
  assign init_ba   = r_ba;
  assign init_end  = r_end;
  assign init_busy = ~r_end;

endmodule

// File: tb/tb_sdram_init_gen.sv
// -----------------------------------------------------------------------------
// tb_sdram_init_gen
//
// Directed bench for sdram_init_gen. It instantiates three configurations:
//   A: default parameters
//   B: BL=4, CL=2, interleaved, single write, 2 refreshes, T_POW=10
//   C: EMR enabled (EMR_VAL=0x20), T_MRD=2, T_POW=10
// Only the configuration under test is out of reset. A mux selects its
// outputs for observation. Cycle numbers count rising edges after reset
// release. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sdram_init_gen;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic rst_n_a = 1'b0, rst_n_b = 1'b0, rst_n_c = 1'b0;
  logic init_req = 1'b0;

  logic [3:0]  cmd_a, cmd_b, cmd_c;
  logic [12:0] addr_a, addr_b, addr_c;
  logic [1:0]  ba_a, ba_b, ba_c;
  logic        end_a, end_b, end_c;
  logic        busy_a, busy_b, busy_c;

  sdram_init_gen u_a (
    .sys_clk(sys_clk), .sys_rst_n(rst_n_a), .init_req(init_req),
    .init_cmd(cmd_a), .init_addr(addr_a), .init_ba(ba_a),
    .init_end(end_a), .init_busy(busy_a)
  );

  sdram_init_gen #(
    .T_POW(10), .AREF_NUM(2), .CAS_LAT(2), .BURST_LEN(4),
    .BURST_TYPE(1), .WRITE_MODE(1)
  ) u_b (
    .sys_clk(sys_clk), .sys_rst_n(rst_n_b), .init_req(init_req),
    .init_cmd(cmd_b), .init_addr(addr_b), .init_ba(ba_b),
    .init_end(end_b), .init_busy(busy_b)
  );

  sdram_init_gen #(
    .T_POW(10), .T_MRD(2), .EMR_EN(1), .EMR_VAL(13'h0020)
  ) u_c (
    .sys_clk(sys_clk), .sys_rst_n(rst_n_c), .init_req(init_req),
    .init_cmd(cmd_c), .init_addr(addr_c), .init_ba(ba_c),
    .init_end(end_c), .init_busy(busy_c)
  );

  int          sel = 0;
  logic [3:0]  obs_cmd;
  logic [12:0] obs_addr;
  logic [1:0]  obs_ba;
  logic        obs_end, obs_busy;

  always_comb begin
    obs_cmd  = cmd_a;
    obs_addr = addr_a;
    obs_ba   = ba_a;
    obs_end  = end_a;
    obs_busy = busy_a;
    if (sel == 1) begin
      obs_cmd  = cmd_b;
      obs_addr = addr_b;
      obs_ba   = ba_b;
      obs_end  = end_b;
      obs_busy = busy_b;
    end else if (sel == 2) begin
      obs_cmd  = cmd_c;
      obs_addr = addr_c;
      obs_ba   = ba_c;
      obs_end  = end_c;
      obs_busy = busy_c;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
             tag, obs, obs, exp, exp);
    end
  endtask

  // Results recorded by one observation window.
  int t_pre, n_pre, n_aref, t_aref1, t_aref_last, gap_min, gap_max;
  int n_mrs, t_end, n_bad_cmd, n_idle_bad, n_busy_bad;
  int t_mrs [2];
  int mrs_addr [2];
  int mrs_ba [2];

  // Watch the bus for up to 'limit' cycles. Stop early when init_end rises.
  // init_req is driven high for cycles req_from..req_to-1.
  task automatic observe(input string tag, input int limit,
                         input int req_from, input int req_to);
    bit done;
    t_pre = -1; n_pre = 0; n_aref = 0; t_aref1 = -1; t_aref_last = -1;
    gap_min = 1 << 30; gap_max = -1; n_mrs = 0; t_end = -1;
    n_bad_cmd = 0; n_idle_bad = 0; n_busy_bad = 0;
    for (int k = 0; k < 2; k++) begin
      t_mrs[k] = -1; mrs_addr[k] = 'h1FFF; mrs_ba[k] = 3;
    end
    done = 1'b0;
    for (int t = 1; t <= limit && !done; t++) begin
      @(negedge sys_clk);
      init_req = (t >= req_from) && (t < req_to);
      case (obs_cmd)
        CMD_NOP: ;
        CMD_PRE: begin
          n_pre++;
          if (t_pre < 0) t_pre = t;
        end
        CMD_AREF: begin
          if (n_aref > 0) begin
            if (t - t_aref_last < gap_min) gap_min = t - t_aref_last;
            if (t - t_aref_last > gap_max) gap_max = t - t_aref_last;
          end else begin
            t_aref1 = t;
          end
          t_aref_last = t;
          n_aref++;
        end
        CMD_LMR: begin
          if (n_mrs < 2) begin
            t_mrs[n_mrs]    = t;
            mrs_addr[n_mrs] = int'(obs_addr);
            mrs_ba[n_mrs]   = int'(obs_ba);
          end
          n_mrs++;
        end
        default: n_bad_cmd++;
      endcase
      if (obs_cmd != CMD_LMR && (obs_addr !== 13'h1FFF || obs_ba !== 2'b11))
        n_idle_bad++;
      if (obs_busy !== ~obs_end) n_busy_bad++;
      if (obs_end === 1'b1) begin
        t_end = t;
        done  = 1'b1;
      end
    end
    init_req = 1'b0;
    $display("[%0t] %s: PRE@%0d AREFx%0d first@%0d last@%0d MRSx%0d @%0d/%0d END@%0d",
             $time, tag, t_pre, n_aref, t_aref1, t_aref_last, n_mrs,
             t_mrs[0], t_mrs[1], t_end);
  endtask

  // Every sequence uses T_RFC = 12, so refreshes are always 14 cycles apart.
  task automatic check_seq(input string tag, input int e_pre, input int e_naref,
                           input int e_aref1, input int e_nmrs,
                           input int e_tlmr, input int e_lmr_addr, input int e_lmr_ba,
                           input int e_temr, input int e_emr_addr, input int e_emr_ba,
                           input int e_end);
    chk({tag, ".pre_cycle"}, t_pre, e_pre);
    chk({tag, ".pre_count"}, n_pre, 1);
    chk({tag, ".aref_count"}, n_aref, e_naref);
    chk({tag, ".aref_first"}, t_aref1, e_aref1);
    chk({tag, ".aref_gap_min"}, gap_min, 14);
    chk({tag, ".aref_gap_max"}, gap_max, 14);
    chk({tag, ".mrs_count"}, n_mrs, e_nmrs);
    chk({tag, ".lmr_cycle"}, t_mrs[0], e_tlmr);
    chk({tag, ".lmr_addr"}, mrs_addr[0], e_lmr_addr);
    chk({tag, ".lmr_ba"}, mrs_ba[0], e_lmr_ba);
    chk({tag, ".emr_cycle"}, t_mrs[1], e_temr);
    chk({tag, ".emr_addr"}, mrs_addr[1], e_emr_addr);
    chk({tag, ".emr_ba"}, mrs_ba[1], e_emr_ba);
    chk({tag, ".end_cycle"}, t_end, e_end);
    chk({tag, ".illegal_cmd"}, n_bad_cmd, 0);
    chk({tag, ".idle_addr_ba"}, n_idle_bad, 0);
    chk({tag, ".busy_vs_end"}, n_busy_bad, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".cmd"}, int'(obs_cmd), int'(CMD_NOP));
    chk({tag, ".addr"}, int'(obs_addr), 'h1FFF);
    chk({tag, ".ba"}, int'(obs_ba), 3);
    chk({tag, ".end"}, int'(obs_end), 0);
    chk({tag, ".busy"}, int'(obs_busy), 1);
  endtask

  task automatic hold_check(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge sys_clk);
      if (obs_end !== 1'b1 || obs_busy !== 1'b0 || obs_cmd !== CMD_NOP) bad++;
    end
    chk({tag, ".done_stable"}, bad, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- Config A: default parameters ----------------
    sel = 0;
    repeat (2) @(negedge sys_clk);
    chk_reset_vals("A.reset");
    rst_n_a = 1'b1;
    observe("A.init", 40000, -1, -1);
    // PRE at T_POW+1 = 33446. AREF 4 cycles of TRP later plus 1 = 33451.
    // Six AREFs end at 33521. LMR at +14 = 33535. END at LMR+8 = 33543.
    // Mode word: WM=0, CL=3, seq, full page = 0x037.
    check_seq("A.init", 33446, 6, 33451, 1, 33535, 'h037, 0,
              -1, 'h1FFF, 3, 33543);
    hold_check("A.done", 6);
    rst_n_a = 1'b0;

    // ---------------- Config B: alternate mode word, re-init ----------------
    sel = 1;
    @(negedge sys_clk);
    chk_reset_vals("B.reset");
    rst_n_b = 1'b1;
    observe("B.init", 300, -1, -1);
    // PRE 11, AREF 16 and 30, LMR 44 with 0x22A, END 52.
    check_seq("B.init", 11, 2, 16, 1, 44, 'h22A, 0, -1, 'h1FFF, 3, 52);
    hold_check("B.done", 5);

    // One-cycle request in DONE: init_end must drop after the sampling edge.
    init_req = 1'b1;
    @(negedge sys_clk);
    init_req = 1'b0;
    chk("B.req.end_drop", int'(obs_end), 0);
    chk("B.req.busy", int'(obs_busy), 1);
    chk("B.req.cmd", int'(obs_cmd), int'(CMD_NOP));
    // Request held high through the refresh and mode-load phase. It must not
    // disturb the sequence. PRE comes next cycle with no power wait.
    observe("B.reinit", 300, 20, 35);
    check_seq("B.reinit", 1, 2, 6, 1, 34, 'h22A, 0, -1, 'h1FFF, 3, 42);
    hold_check("B.redone", 5);

    // An asynchronous reset in DONE clears init_end without a clock edge.
    #2 rst_n_b = 1'b0;
    #1;
    chk("B.async.end", int'(obs_end), 0);
    chk("B.async.busy", int'(obs_busy), 1);
    @(negedge sys_clk);

    // ---------------- Config C: EMR, reset mid-sequence ----------------
    sel = 2;
    @(negedge sys_clk);
    chk_reset_vals("C.reset");
    rst_n_c = 1'b1;
    observe("C.init", 300, -1, -1);
    // PRE 11. AREFs at 16..86. LMR 100. EMR 104 (T_MRD+2) with ba=2 and
    // addr=0x20. END 108.
    check_seq("C.init", 11, 6, 16, 2, 100, 'h037, 0, 104, 'h020, 2, 108);

    rst_n_c = 1'b0;
    @(negedge sys_clk);
    rst_n_c = 1'b1;
    // Cycle 44 shows the third AREF while the FSM already sits in TRFC.
    observe("C.partial", 44, -1, -1);
    chk("C.partial.aref_count", n_aref, 3);
    chk("C.partial.aref_last", t_aref_last, 44);
    chk("C.partial.no_end", t_end, -1);
    #2 rst_n_c = 1'b0;
    #1;
    chk_reset_vals("C.async");
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst_n_c = 1'b1;
    observe("C.after_rst", 300, -1, -1);
    check_seq("C.after_rst", 11, 6, 16, 2, 100, 'h037, 0, 104, 'h020, 2, 108);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
